// File: rtl/lc3b_ucode_pkg.sv
// LC-3b control-store word layout, branch condition encodings and sequencer defaults.
// Shared by the microsequencer top and its next-address sub-module.
package lc3b_ucode_pkg;

  localparam int unsigned IRD_BIT = 34;
  localparam int unsigned COND_HI = 33;
  localparam int unsigned COND_LO = 32;
  localparam int unsigned J_HI    = 31;
  localparam int unsigned J_LO    = 26;
  localparam int unsigned CTRL_W  = 26;
  localparam int unsigned WORD_W  = 35;
  localparam int unsigned STATE_W = 6;

  localparam logic [STATE_W-1:0] FETCH_STATE_DFLT = 6'd18;

  typedef enum logic [1:0] {
    COND_NONE = 2'd0,
    COND_R    = 2'd1,
    COND_BEN  = 2'd2,
    COND_IR11 = 2'd3
  } cond_e;

  // Packed view of one microinstruction; the field order matches the bit indices above.
  typedef struct packed {
    logic               ird;
    cond_e              cond;
    logic [STATE_W-1:0] j;
    logic [CTRL_W-1:0]  ctrl;
  } uinst_t;

  function automatic uinst_t decode_word(input logic [WORD_W-1:0] w);
    return uinst_t'(w);
  endfunction

endpackage

// File: rtl/lc3b_microsequencer_if.sv
// Control-store and datapath bus between the microsequencer (master) and its
// surroundings (slave): store address/word, IR, BEN, memory ready and datapath controls.
interface lc3b_microsequencer_if;
  import lc3b_ucode_pkg::*;

  logic [STATE_W-1:0] cs_addr;
  logic [WORD_W-1:0]  cs_word;
  logic [15:0]        ir;
  logic               ben;
  logic               mem_ready;
  logic [CTRL_W-1:0]  ctrl;

  modport master (
    output cs_addr,
    output ctrl,
    input  cs_word,
    input  ir,
    input  ben,
    input  mem_ready
  );

  modport slave (
    input  cs_addr,
    input  ctrl,
    output cs_word,
    output ir,
    output ben,
    output mem_ready
  );

endinterface

// File: rtl/lc3b_next_addr.sv
// Combinational LC-3b next-microaddress logic: IRD opcode dispatch, or J with the
// COND-selected bit ORed in (never added, so J bits already set stay set).
module lc3b_next_addr
  import lc3b_ucode_pkg::*;
(
  input  logic               ird,
  input  cond_e              cond,
  input  logic [STATE_W-1:0] j,
  input  logic               ben,
  input  logic               mem_ready,
  input  logic [3:0]         ir_op,
  input  logic               ir11,
  output logic [STATE_W-1:0] next_addr
);

  logic [2:0] cbits;

  always_comb begin
    cbits     = '0;
    cbits[2]  = (cond == COND_BEN)  & ben;
    cbits[1]  = (cond == COND_R)    & mem_ready;
    cbits[0]  = (cond == COND_IR11) & ir11;
    next_addr = ird ? {2'b00, ir_op} : (j | {3'b000, cbits});
  end

endmodule

// File: rtl/lc3b_microsequencer.sv
// LC-3b microsequencer: microstate register driving the control-store address,
// gated datapath controls, memory-wait stall statistics and a sticky wait timeout.
module lc3b_microsequencer
  import lc3b_ucode_pkg::*;
#(
  parameter logic [STATE_W-1:0] FETCH_STATE = FETCH_STATE_DFLT,
  parameter int unsigned        WAIT_LIMIT  = 15,
  parameter int unsigned        STALL_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  lc3b_microsequencer_if.master    bus,
  output logic [STATE_W-1:0]       state,
  output logic                     mem_timeout,
  output logic [STALL_W-1:0]       stall_count
);

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_LIMIT);

  logic [STATE_W-1:0] state_q, state_d;
  logic [7:0]         wait_cnt_q, wait_cnt_d;
  logic               timeout_q, timeout_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  uinst_t             uinst;
  logic [STATE_W-1:0] next_addr;
  logic               advance;
  logic               wait_cyc;
  logic               unused_ir;

  assign uinst     = decode_word(bus.cs_word);
  assign unused_ir = ^bus.ir[10:0];

  lc3b_next_addr u_next_addr (
    .ird       (uinst.ird),
    .cond      (uinst.cond),
    .j         (uinst.j),
    .ben       (bus.ben),
    .mem_ready (bus.mem_ready),
    .ir_op     (bus.ir[15:12]),
    .ir11      (bus.ir[11]),
    .next_addr (next_addr)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    stall_d    = stall_q;
    advance    = run && !timeout_q;
    wait_cyc   = advance && (uinst.cond == COND_R) && !bus.mem_ready;

    if (advance) begin
      state_d = next_addr;
      if (wait_cyc && (stall_q != '1)) begin
        stall_d = stall_q + 1'b1;
      end
      // The wait run restarts whenever memory answers or the microstate moves on.
      if (bus.mem_ready || (next_addr != state_q)) begin
        wait_cnt_d = '0;
      end else if (wait_cyc) begin
        if (wait_cnt_q >= WAIT_LIM) begin
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
    end

    bus.ctrl = (rst_n && advance) ? uinst.ctrl : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH_STATE;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      stall_q    <= stall_d;
    end
  end

  assign bus.cs_addr = state_q;
  assign state       = state_q;
  assign mem_timeout = timeout_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_lc3b_microsequencer.sv
// Directed bench for lc3b_microsequencer: a small microprogram ROM, a table of
// single-cycle sequencing vectors, and hand-written memory-wait/timeout/saturation runs.
module tb_lc3b_microsequencer;
  import lc3b_ucode_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [15:0] ir;
  logic        ben;
  logic        mem_ready;

  logic [5:0]  state1, state2;
  logic        tmo1, tmo2;
  logic [15:0] stall1;
  logic [3:0]  stall2;

  int checks   = 0;
  int failures = 0;

  lc3b_microsequencer_if bus1();
  lc3b_microsequencer_if bus2();

  function automatic logic [25:0] cbits(input logic [5:0] a);
    return {20'hA5A5A, a};
  endfunction

  // Microprogram: 18->33(R wait)->35->32(IRD); 0 BR; 1 R|J=3; 4 IR11|J=20; others zero.
  function automatic logic [34:0] rom(input logic [5:0] a);
    logic [34:0] w;
    case (a)
      6'd18:  w = {1'b0, 2'd0, 6'd33, cbits(a)};
      6'd33:  w = {1'b0, 2'd1, 6'd33, cbits(a)};
      6'd35:  w = {1'b0, 2'd0, 6'd32, cbits(a)};
      6'd32:  w = {1'b1, 2'd0, 6'd0,  cbits(a)};
      6'd0:   w = {1'b0, 2'd2, 6'd18, cbits(a)};
      6'd1:   w = {1'b0, 2'd1, 6'd3,  cbits(a)};
      6'd4:   w = {1'b0, 2'd3, 6'd20, cbits(a)};
      6'd14, 6'd20, 6'd21, 6'd22:
              w = {1'b0, 2'd0, 6'd18, cbits(a)};
      default: w = '0;
    endcase
    return w;
  endfunction

  assign bus1.cs_word   = rom(bus1.cs_addr);
  assign bus1.ir        = ir;
  assign bus1.ben       = ben;
  assign bus1.mem_ready = mem_ready;
  assign bus2.cs_word   = rom(bus2.cs_addr);
  assign bus2.ir        = ir;
  assign bus2.ben       = ben;
  assign bus2.mem_ready = mem_ready;

  lc3b_microsequencer #(.FETCH_STATE(6'd18), .WAIT_LIMIT(15), .STALL_W(16)) dut (
    .clk (clk), .rst_n (rst_n), .run (run), .bus (bus1.master),
    .state (state1), .mem_timeout (tmo1), .stall_count (stall1)
  );

  lc3b_microsequencer #(.FETCH_STATE(6'd18), .WAIT_LIMIT(255), .STALL_W(4)) dut_sat (
    .clk (clk), .rst_n (rst_n), .run (run), .bus (bus2.master),
    .state (state2), .mem_timeout (tmo2), .stall_count (stall2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b1; mem_ready = 1'b0; ben = 1'b0; ir = '0;
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    string      name;
    logic       run;
    logic [15:0] ir;
    logic       ben;
    logic       mr;
    logic [5:0] cur;
    logic [5:0] nxt;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"fetch18",   1'b1, 16'h0000, 1'b0, 1'b0, 6'd18, 6'd33});
    vecs.push_back('{"mem_rdy",   1'b1, 16'h0000, 1'b0, 1'b1, 6'd33, 6'd35});
    vecs.push_back('{"to_dec",    1'b1, 16'h0000, 1'b0, 1'b0, 6'd35, 6'd32});
    vecs.push_back('{"dec_1",     1'b1, 16'h1234, 1'b0, 1'b0, 6'd32, 6'd1});
    vecs.push_back('{"or_not_add",1'b1, 16'h0000, 1'b0, 1'b1, 6'd1,  6'd3});
    vecs.push_back('{"unused3",   1'b1, 16'h0000, 1'b0, 1'b0, 6'd3,  6'd0});
    vecs.push_back('{"br_ben1",   1'b1, 16'h0000, 1'b1, 1'b0, 6'd0,  6'd22});
    vecs.push_back('{"s22",       1'b1, 16'h0000, 1'b0, 1'b0, 6'd22, 6'd18});
    vecs.push_back('{"run0_hold", 1'b0, 16'h0000, 1'b0, 1'b1, 6'd18, 6'd18});
    vecs.push_back('{"fetch18b",  1'b1, 16'h0000, 1'b0, 1'b0, 6'd18, 6'd33});
    vecs.push_back('{"mem_rdyb",  1'b1, 16'h0000, 1'b0, 1'b1, 6'd33, 6'd35});
    vecs.push_back('{"to_decb",   1'b1, 16'h0000, 1'b0, 1'b0, 6'd35, 6'd32});
    vecs.push_back('{"dec_e",     1'b1, 16'hE000, 1'b0, 1'b0, 6'd32, 6'd14});
    vecs.push_back('{"s14",       1'b1, 16'h0000, 1'b0, 1'b0, 6'd14, 6'd18});
    vecs.push_back('{"fetch18c",  1'b1, 16'h0000, 1'b0, 1'b0, 6'd18, 6'd33});
    vecs.push_back('{"mem_rdyc",  1'b1, 16'h0000, 1'b0, 1'b1, 6'd33, 6'd35});
    vecs.push_back('{"to_decc",   1'b1, 16'h0000, 1'b0, 1'b0, 6'd35, 6'd32});
    vecs.push_back('{"dec_0",     1'b1, 16'h0800, 1'b0, 1'b0, 6'd32, 6'd0});
    vecs.push_back('{"br_ben0",   1'b1, 16'h0800, 1'b0, 1'b1, 6'd0,  6'd18});
    vecs.push_back('{"fetch18d",  1'b1, 16'h0000, 1'b0, 1'b0, 6'd18, 6'd33});
    vecs.push_back('{"mem_rdyd",  1'b1, 16'h0000, 1'b0, 1'b1, 6'd33, 6'd35});
    vecs.push_back('{"to_decd",   1'b1, 16'h0000, 1'b0, 1'b0, 6'd35, 6'd32});
    vecs.push_back('{"dec_4a",    1'b1, 16'h4800, 1'b0, 1'b0, 6'd32, 6'd4});
    vecs.push_back('{"ir11_1",    1'b1, 16'h4800, 1'b0, 1'b0, 6'd4,  6'd21});
    vecs.push_back('{"s21",       1'b1, 16'h0000, 1'b0, 1'b0, 6'd21, 6'd18});
    vecs.push_back('{"fetch18e",  1'b1, 16'h0000, 1'b0, 1'b0, 6'd18, 6'd33});
    vecs.push_back('{"mem_rdye",  1'b1, 16'h0000, 1'b0, 1'b1, 6'd33, 6'd35});
    vecs.push_back('{"to_dece",   1'b1, 16'h0000, 1'b0, 1'b0, 6'd35, 6'd32});
    vecs.push_back('{"dec_4b",    1'b1, 16'h4000, 1'b0, 1'b0, 6'd32, 6'd4});
    vecs.push_back('{"ir11_0",    1'b1, 16'h4000, 1'b0, 1'b0, 6'd4,  6'd20});
    vecs.push_back('{"s20",       1'b1, 16'h0000, 1'b0, 1'b0, 6'd20, 6'd18});

    // Reset state, with ctrl forced low while rst_n is asserted
    rst_n = 1'b0; run = 1'b1; mem_ready = 1'b0; ben = 1'b0; ir = '0;
    tick();
    chk("rst_state", 32'(state1), 32'd18);
    chk("rst_addr",  32'(bus1.cs_addr), 32'd18);
    chk("rst_stall", 32'(stall1), 32'd0);
    chk("rst_tmo",   32'(tmo1), 32'd0);
    chk("rst_ctrl",  32'(bus1.ctrl), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run = vecs[i].run; ir = vecs[i].ir; ben = vecs[i].ben; mem_ready = vecs[i].mr;
      #1;
      chk({vecs[i].name, "_cur"}, 32'(state1), 32'(vecs[i].cur));
      chk({vecs[i].name, "_ctrl"}, 32'(bus1.ctrl),
          vecs[i].run ? 32'(rom(vecs[i].cur) & 35'h3FFFFFF) : 32'd0);
      tick();
      chk({vecs[i].name, "_nxt"}, 32'(state1), 32'(vecs[i].nxt));
    end
    chk("tbl_stall", 32'(stall1), 32'd0);

    // Memory wait: three not-ready cycles in 33, then ready
    do_reset();
    tick();
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      chk("wait_hold", 32'(state1), 32'd33);
    end
    mem_ready = 1'b1;
    tick();
    chk("wait_done", 32'(state1), 32'd35);
    chk("wait_stall", 32'(stall1), 32'd3);
    chk("wait_tmo", 32'(tmo1), 32'd0);

    // Ready arriving exactly when the wait count reaches the limit still advances
    do_reset();
    tick();
    for (int unsigned k = 0; k < 15; k++) tick();
    mem_ready = 1'b1;
    tick();
    chk("lim_rdy_state", 32'(state1), 32'd35);
    chk("lim_rdy_tmo", 32'(tmo1), 32'd0);
    chk("lim_rdy_stall", 32'(stall1), 32'd15);

    // Timeout: 15 waits are tolerated, the 16th sets the sticky flag
    do_reset();
    tick();
    for (int unsigned k = 0; k < 15; k++) tick();
    chk("tmo_before", 32'(tmo1), 32'd0);
    tick();
    chk("tmo_set", 32'(tmo1), 32'd1);
    tick();
    chk("tmo_state", 32'(state1), 32'd33);
    chk("tmo_ctrl", 32'(bus1.ctrl), 32'd0);
    mem_ready = 1'b1;
    tick();
    chk("tmo_frozen", 32'(state1), 32'd33);
    chk("tmo_sticky", 32'(tmo1), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("tmo_rst_ctrl", 32'(bus1.ctrl), 32'd0);
    tick();
    rst_n = 1'b1;
    chk("tmo_rst_state", 32'(state1), 32'd18);
    chk("tmo_rst_flag", 32'(tmo1), 32'd0);
    chk("tmo_rst_stall", 32'(stall1), 32'd0);

    // Saturation on the 4-bit stall counter, then run=0 holds everything
    do_reset();
    tick();
    for (int unsigned k = 0; k < 15; k++) tick();
    chk("sat_15", 32'(stall2), 32'd15);
    for (int unsigned k = 0; k < 5; k++) tick();
    chk("sat_20", 32'(stall2), 32'd15);
    chk("sat_state", 32'(state2), 32'd33);
    chk("sat_tmo", 32'(tmo2), 32'd0);
    run = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("run0_ctrl", 32'(bus2.ctrl), 32'd0);
    for (int unsigned k = 0; k < 3; k++) tick();
    chk("run0_state", 32'(state2), 32'd33);
    chk("run0_stall", 32'(stall2), 32'd15);
    run = 1'b1;
    tick();
    chk("run1_resume", 32'(state2), 32'd35);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
